bw_seq_mult: RTL

//   Parametrised, iterative Baugh-Wooley multiplier, AW x BW -> AW+BW bits, with per-operation

---
 rtl/bw_seq_mult.sv | 115 +++++++++++
 1 files changed

// File: rtl/bw_seq_mult.sv
// Iterative Baugh-Wooley multiplier: AW x BW -> AW+BW bits, one partial-product row per clock.
// T selects two's-complement (1) or unsigned (0) operands for each operation.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   A, B, T               multiplicand, multiplier, signed-mode select (latched on acceptance)
//   out_valid / out_ready result handshake
//   out                   product, held until the next product is loaded
//   busy                  high while an operation is running or waiting to be taken
module bw_seq_mult #(
  parameter int unsigned AW = 7,
  parameter int unsigned BW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic             T,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW+BW-1:0] out,
  output logic             busy
);

  localparam int unsigned P  = AW + BW;
  localparam int unsigned CW = $clog2(BW);

  // Sum of the Baugh-Wooley correction terms, folded modulo 2^P.
  localparam logic [P-1:0] Corr = (P'(1) << (AW - 1)) + (P'(1) << (BW - 1)) + (P'(1) << (P - 1));

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t          state;
  logic [AW-1:0]   a_reg;
  logic [BW-1:0]   b_reg;
  logic            t_reg;
  logic [P-1:0]    acc;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   row;
  logic            last_row;
  logic [P-1:0]    acc_next;

  // Current partial-product row. In signed mode the cross-sign terms (sign bit of exactly one
  // operand) are inverted; the sign-by-sign term stays positive.
  always_comb begin
    row      = '0;
    last_row = (cnt == CW'(BW - 1));
    for (int j = 0; j < AW; j++) begin
      row[j] = a_reg[j] & b_reg[cnt];
      if (t_reg && ((j == AW - 1) != last_row)) begin
        row[j] = ~row[j];
      end
    end
    acc_next = acc + (P'(row) << cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      acc       <= '0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      t_reg     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            t_reg    <= T;
            acc      <= T ? Corr : '0;
            cnt      <= '0;
            state    <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          acc <= acc_next;
          if (last_row) begin
            out       <= acc_next;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
